// File: rtl/mem_bus_arbiter.sv
// Arbitrates instruction-fetch and data requesters onto one Avalon-MM port, alternating grants when both are pending.
// Ack pulses 2+W cycles after the grant cycle (W = waitrequest cycles); the granted request is frozen while the bus stalls.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t      state_q, state_d;
   logic        last_data_q, last_data_d;   // last_grant: 0 = fetch, 1 = data
   logic        gnt_data_q, gnt_data_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [3:0]  be_q, be_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic        if_ack_q, if_ack_d;
   logic        d_ack_q, d_ack_d;
   logic        err_q, err_d;
   logic [31:0] wait_cnt_q, wait_cnt_d;
   logic        pick_data;
   logic        timeout_hit;

   // Data wins when it is the only requester or when fetch was served last.
   assign pick_data   = d_req & (~if_req | ~last_data_q);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == TIMEOUT_CYCLES - 32'd1);

   always_comb begin
      state_d     = state_q;
      last_data_d = last_data_q;
      gnt_data_d  = gnt_data_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      be_d        = be_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      if_ack_d    = 1'b0;
      d_ack_d     = 1'b0;
      err_d       = err_q;
      wait_cnt_d  = wait_cnt_q;

      case (state_q)
         IDLE: begin
            if (if_req | d_req) begin
               gnt_data_d  = pick_data;
               last_data_d = pick_data;
               wait_cnt_d  = '0;
               state_d     = BUS;
               if (pick_data) begin
                  addr_d  = d_addr & 32'hFFFF_FFFC;
                  wdata_d = d_wdata;
                  be_d    = d_be;
                  rd_d    = ~d_we;
                  wr_d    = d_we;
               end else begin
                  addr_d  = if_addr & 32'hFFFF_FFFC;
                  wdata_d = '0;
                  be_d    = 4'hF;
                  rd_d    = 1'b1;
                  wr_d    = 1'b0;
               end
            end
         end
         BUS: begin
            if (!avm_waitrequest) begin
               rdata_d  = rd_q ? avm_readdata : '0;
               rd_d     = 1'b0;
               wr_d     = 1'b0;
               if_ack_d = ~gnt_data_q;
               d_ack_d  = gnt_data_q;
               state_d  = RESP;
            end else if (timeout_hit) begin
               rdata_d  = '0;
               err_d    = 1'b1;
               rd_d     = 1'b0;
               wr_d     = 1'b0;
               if_ack_d = ~gnt_data_q;
               d_ack_d  = gnt_data_q;
               state_d  = RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + 32'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         last_data_q <= 1'b0;
         gnt_data_q  <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         be_q        <= '0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         if_ack_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         err_q       <= 1'b0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         last_data_q <= last_data_d;
         gnt_data_q  <= gnt_data_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         be_q        <= be_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         if_ack_q    <= if_ack_d;
         d_ack_q     <= d_ack_d;
         err_q       <= err_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   assign avm_address    = addr_q;
   assign avm_read       = rd_q;
   assign avm_write      = wr_q;
   assign avm_writedata  = wdata_q;
   assign avm_byteenable = be_q;
   assign if_ack         = if_ack_q;
   assign d_ack          = d_ack_q;
   assign if_rdata       = rdata_q;
   assign d_rdata        = rdata_q;
   assign busy           = (state_q != IDLE);
   assign timeout_err    = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

   localparam int unsigned TMO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, d_req, d_we, avm_waitrequest;
   logic [31:0] if_addr, d_addr, d_wdata, avm_readdata;
   logic [3:0]  d_be;
   logic        if_ack, d_ack, avm_read, avm_write, busy, timeout_err;
   logic [31:0] if_rdata, d_rdata, avm_address, avm_writedata;
   logic [3:0]  avm_byteenable;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model: one outstanding transfer, its wait count, and the response slot.
   bit          started = 1'b0;
   bit          m_onbus, m_resp, m_cur_data, m_cur_we, m_last_data, m_err;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_be;
   int          m_waits;

   always @(posedge clk) begin
      started = 1'b1;
      if (reset) begin
         m_onbus = 0; m_resp = 0; m_cur_data = 0; m_cur_we = 0; m_last_data = 0; m_err = 0;
         m_addr = '0; m_wdata = '0; m_rdata = '0; m_be = '0; m_waits = 0;
      end else if (m_resp) begin
         m_resp = 0;
      end else if (m_onbus) begin
         if (!avm_waitrequest) begin
            m_rdata = m_cur_we ? 32'h0 : avm_readdata;
            m_onbus = 0; m_resp = 1;
         end else begin
            m_waits = m_waits + 1;
            if (m_waits >= int'(TMO)) begin
               m_rdata = '0; m_err = 1; m_onbus = 0; m_resp = 1;
            end
         end
      end else if (if_req || d_req) begin
         m_cur_data  = d_req && (!if_req || !m_last_data);
         m_last_data = m_cur_data;
         if (m_cur_data) begin
            m_addr = {d_addr[31:2], 2'b00}; m_cur_we = d_we; m_wdata = d_wdata; m_be = d_be;
         end else begin
            m_addr = {if_addr[31:2], 2'b00}; m_cur_we = 0; m_wdata = '0; m_be = 4'hF;
         end
         m_onbus = 1; m_waits = 0;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("busy", busy, m_onbus || m_resp);
         chk("avm_read", avm_read, m_onbus && !m_cur_we);
         chk("avm_write", avm_write, m_onbus && m_cur_we);
         chk("if_ack", if_ack, m_resp && !m_cur_data);
         chk("d_ack", d_ack, m_resp && m_cur_data);
         chk("timeout_err", timeout_err, m_err);
         if (m_onbus) begin
            chk("avm_address", avm_address, m_addr);
            chk("avm_byteenable", avm_byteenable, m_be);
            if (m_cur_we) chk("avm_writedata", avm_writedata, m_wdata);
         end
         if (m_resp && !m_cur_data) chk("if_rdata", if_rdata, m_rdata);
         if (m_resp && m_cur_data)  chk("d_rdata", d_rdata, m_rdata);
      end
   end

   bit prev_if_ack, prev_d_ack, cur_if_ack, cur_d_ack;
   int stuck;

   initial begin
      reset = 1; if_req = 0; d_req = 0; d_we = 0; avm_waitrequest = 0;
      if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; avm_readdata = '0;
      tick; tick;
      chk("rst_read", avm_read, 0);
      chk("rst_write", avm_write, 0);
      chk("rst_address", avm_address, 0);
      chk("rst_be", avm_byteenable, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", timeout_err, 0);
      chk("rst_acks", {if_ack, d_ack}, 0);
      reset = 0;

      // Single fetch, no wait
      if_req = 1; if_addr = 32'hBFC0_0000; avm_readdata = 32'h2402_0005;
      tick;
      chk("t1_read", avm_read, 1);
      chk("t1_addr", avm_address, 32'hBFC0_0000);
      chk("t1_be", avm_byteenable, 4'hF);
      tick;
      chk("t1_ack", if_ack, 1);
      chk("t1_rdata", if_rdata, 32'h2402_0005);
      chk("t1_read_dropped", avm_read, 0);
      chk("t1_model_rdata", m_rdata, 32'h2402_0005);
      tick;
      if_req = 0;

      // Unaligned write with 3 wait cycles; inputs change mid-stall
      d_req = 1; d_we = 1; d_addr = 32'h1003; d_be = 4'b1000; d_wdata = 32'hAB00_0000;
      avm_waitrequest = 1; avm_readdata = 32'hDEAD_BEEF;
      for (int k = 1; k <= 4; k++) begin
         tick;
         chk("t2_write", avm_write, 1);
         chk("t2_addr", avm_address, 32'h1000);
         chk("t2_be", avm_byteenable, 4'b1000);
         chk("t2_wdata", avm_writedata, 32'hAB00_0000);
         chk("t2_no_ack", d_ack, 0);
         if (k == 2) begin d_addr = 32'h2222_2220; d_wdata = 32'h1234_5678; d_be = 4'hF; end
         if (k == 4) avm_waitrequest = 0;
      end
      tick;
      chk("t2_ack", d_ack, 1);
      chk("t2_rdata", d_rdata, 0);
      chk("t2_write_dropped", avm_write, 0);
      tick;
      d_req = 0;

      // Alternating grant after reset: data, then fetch; later fetch wins over data
      reset = 1;
      tick;
      reset = 0;
      if_req = 1; if_addr = 32'h400; d_req = 1; d_we = 0; d_addr = 32'h808; avm_readdata = 32'h1111_1111;
      tick;
      chk("t3_first_is_data", avm_address, 32'h808);
      chk("t3_model_first_data", m_cur_data, 1);
      tick;
      chk("t3_d_ack", {if_ack, d_ack}, 2'b01);
      chk("t3_d_rdata", d_rdata, 32'h1111_1111);
      tick;
      d_req = 0; avm_readdata = 32'h2222_2222;
      tick;
      chk("t3_second_is_fetch", avm_address, 32'h400);
      tick;
      chk("t3_if_ack", {if_ack, d_ack}, 2'b10);
      chk("t3_if_rdata", if_rdata, 32'h2222_2222);
      tick;
      if_req = 0; d_req = 1; d_we = 1; d_addr = 32'hC00; d_wdata = 32'h5; d_be = 4'h1;
      tick; tick;
      chk("t3_lone_d_ack", d_ack, 1);
      tick;
      d_req = 0;
      tick;
      if_req = 1; if_addr = 32'h500; d_req = 1; d_we = 0; d_addr = 32'h900;
      tick;
      chk("t3_fetch_wins", avm_address, 32'h500);
      tick;
      chk("t3_fetch_ack", {if_ack, d_ack}, 2'b10);
      tick;
      if_req = 0;
      tick;
      chk("t3_data_next", avm_address, 32'h900);
      tick;
      chk("t3_data_ack", d_ack, 1);
      tick;
      d_req = 0;

      // Timeout with waitrequest stuck
      if_req = 1; if_addr = 32'h40; avm_waitrequest = 1;
      for (int k = 1; k <= 8; k++) begin
         tick;
         chk("t4_read_held", avm_read, 1);
         chk("t4_no_err_yet", timeout_err, 0);
      end
      tick;
      chk("t4_read_dropped", avm_read, 0);
      chk("t4_ack", if_ack, 1);
      chk("t4_rdata", if_rdata, 0);
      chk("t4_err", timeout_err, 1);
      chk("t4_model_err", m_err, 1);
      tick;
      if_req = 0;
      tick; tick;
      chk("t4_err_sticky", timeout_err, 1);
      reset = 1;
      tick;
      reset = 0; avm_waitrequest = 0;
      chk("t4_err_cleared", timeout_err, 0);

      // Reset during a stalled read
      if_req = 1; if_addr = 32'h80; avm_waitrequest = 1;
      tick;
      chk("t5_read", avm_read, 1);
      tick;
      reset = 1;
      tick;
      chk("t5_read_off", avm_read, 0);
      chk("t5_busy_off", busy, 0);
      chk("t5_no_ack", if_ack, 0);
      reset = 0; avm_waitrequest = 0; avm_readdata = 32'h3333_3333;
      tick;
      chk("t5_reissue", avm_read, 1);
      chk("t5_no_ack2", if_ack, 0);
      tick;
      chk("t5_ack", if_ack, 1);
      chk("t5_rdata", if_rdata, 32'h3333_3333);
      tick;
      if_req = 0;
      tick;

      // Randomized traffic; requesters obey the drop-after-ack rule
      prev_if_ack = 0; prev_d_ack = 0; stuck = 0;
      for (int c = 0; c < 4000; c++) begin
         cur_if_ack = if_ack;
         cur_d_ack  = d_ack;
         reset = ($urandom_range(0, 199) == 0);
         if (if_req && prev_if_ack) if_req = 0;
         else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1; if_addr = $urandom;
         end
         if (d_req && prev_d_ack) d_req = 0;
         else if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1; d_we = $urandom_range(0, 1) == 1; d_addr = $urandom;
            d_wdata = $urandom; d_be = 4'($urandom);
         end else if (d_req && $urandom_range(0, 9) == 0) begin
            d_addr = $urandom; d_wdata = $urandom;
         end
         if (stuck > 0) begin
            avm_waitrequest = 1; stuck--;
         end else if ($urandom_range(0, 49) == 0) begin
            avm_waitrequest = 1; stuck = 10;
         end else begin
            avm_waitrequest = ($urandom_range(0, 2) == 0);
         end
         avm_readdata = $urandom;
         prev_if_ack = cur_if_ack;
         prev_d_ack  = cur_d_ack;
         tick;
      end

      reset = 1; if_req = 0; d_req = 0;
      tick; tick;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
